fetch_sequencer: RTL

Program-counter and fetch controller for the 20-bit pipelined processor. It drives the program-memory address and registers the fetched word into the pipeline's instruction register. Each cycle it arbitrates between stall hold, branch redirect, interrupt entry/return and halt. It sits between program memory and decode, and consumes the stall outputs of the stall control logic and the branch result from execute.

---
 rtl/fetch_sequencer.sv | 73 +++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch control with stall, branch, interrupt and halt arbitration
module fetch_sequencer #(
   parameter int              PC_W    = 8,
   parameter logic [PC_W-1:0] INT_VEC = 8'hF0,
   parameter logic [19:0]     NOP     = 20'h00000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [19:0]     ins_pm,
   input  logic            stall,
   input  logic            stall_pm,
   input  logic            jmp_taken,
   input  logic [PC_W-1:0] jmp_addr,
   input  logic            int_req,
   input  logic            reti,
   output logic [PC_W-1:0] pm_addr,
   output logic [19:0]     ins,
   output logic            int_ack,
   output logic            in_isr,
   output logic            halted
);
   typedef enum logic {RUN, HALT} state_t;
   state_t          state;
   logic [PC_W-1:0] pc, epc, pc_inc;
   assign pc_inc  = pc + 1'b1;
   assign pm_addr = pc;
   assign halted  = state == HALT;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pc      <= '0;
         epc     <= '0;
         ins     <= NOP;
         in_isr  <= 1'b0;
         int_ack <= 1'b0;
         state   <= RUN;
      end else begin
         int_ack <= 1'b0;
         if (state == HALT) begin
            ins <= NOP;
            if (jmp_taken) begin
               pc    <= jmp_addr;
               state <= RUN;
            end else if (int_req) begin
               epc     <= pc_inc;
               pc      <= INT_VEC;
               in_isr  <= 1'b1;
               int_ack <= 1'b1;
               state   <= RUN;
            end
         end else if (jmp_taken) begin
            pc  <= jmp_addr;
            ins <= NOP;
         end else if (reti && in_isr) begin
            pc     <= epc;
            in_isr <= 1'b0;
            ins    <= NOP;
         end else if (int_req && !in_isr && !stall) begin
            epc     <= pc;
            pc      <= INT_VEC;
            in_isr  <= 1'b1;
            int_ack <= 1'b1;
            ins     <= NOP;
         end else if (!stall) begin
            if (stall_pm) ins <= NOP;
            else begin
               ins <= ins_pm;
               // a fetched HLT stays at its own address until woken
               if (ins_pm[19:16] == 4'hF) state <= HALT;
               else pc <= pc_inc;
            end
         end
      end
endmodule
